lsu_mem_slave: RTL and testbench

Memory-side responder for the LSU data-memory port. It accepts one load or store request at a time from the LSU over a valid/ready request channel and holds a local array of 64-bit words. It applies byte-masked writes, returns masked read data after a programmable latency, and flags out-of-range accesses. It stands in for the DPI-C pmem model wherever a synthesizable, cycle-accurate data memory is required.

---
 rtl/lsu_mem_slave.sv | 120 ++++++++++++
 tb/tb_lsu_mem_slave.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_slave.sv
// Synthesizable data-memory responder for the LSU port: one request in flight,
// byte-masked stores, masked loads after a fixed latency, out-of-range flagging.
module lsu_mem_slave #(
    parameter int unsigned DEPTH   = 1024,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic        req_wen,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_mask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic        live;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic        wen_q;
    logic [7:0]  mask_q;

    logic [63:0] offset;
    logic [63:0] index;
    logic [63:0] lane_mask;
    logic        in_range;
    logic        accept;
    logic        access;

    logic [63:0] mem [DEPTH];

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = live;
                if (req_valid && live) state_next = WAIT;
            end
            WAIT: begin
                if (cnt == 4'd0) state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    assign accept = req_ready && req_valid;
    assign access = (state == WAIT) && (cnt == 4'd0);

    always_comb begin
        offset    = addr_q - BASE;
        index     = offset >> 3;
        in_range  = (addr_q >= BASE) && (index < 64'(DEPTH));
        lane_mask = '0;
        for (int i = 0; i < 8; i++) lane_mask[8*i +: 8] = {8{mask_q[i]}};
    end

    // live holds req_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live       <= 1'b0;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wen_q      <= 1'b0;
            mask_q     <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            live <= 1'b1;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wen_q   <= req_wen;
                mask_q  <= req_mask;
                cnt     <= 4'(LATENCY - 1);
            end else if (state == WAIT) begin
                if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    resp_err   <= !in_range;
                    resp_rdata <= (in_range && !wen_q) ? (mem[index[IDX_W-1:0]] & lane_mask) : '0;
                end
            end
        end
    end

    // NOTE: the array is deliberately not reset; only the control path needs a known state.
    always_ff @(posedge clk) begin
        if (access && wen_q && in_range) begin
            for (int i = 0; i < 8; i++) begin
                if (mask_q[i]) mem[index[IDX_W-1:0]][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_slave.sv
// Self-checking bench: three responders (LATENCY 2, 1, 15) each driven by directed and
// random traffic and compared every cycle against a transaction-level memory model.
module tb_lsu_mem_slave;
    localparam int unsigned DEPTH = 1024;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam logic [63:0] LIMIT = BASE + 64'(DEPTH) * 64'd8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input int lat, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL lat=%0d %s: got 0x%016h, expected 0x%016h at %0t", lat, name, act, exp, $time);
        end
    endtask

    task automatic timeout(input int lat, input string what);
        n_checks++;
        n_errors++;
        $display("FAIL lat=%0d timeout waiting for %s at %0t", lat, what, $time);
    endtask

    function automatic logic [63:0] lanes(input logic [7:0] m);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = m[i] ? 8'hFF : 8'h00;
        return r;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 15;

        logic        rst_n;
        logic        req_valid  = 1'b0;
        logic        req_ready;
        logic [63:0] req_addr   = '0;
        logic        req_wen    = 1'b0;
        logic [63:0] req_wdata  = '0;
        logic [7:0]  req_mask   = '0;
        logic        resp_valid;
        logic        resp_ready = 1'b1;
        logic [63:0] resp_rdata;
        logic        resp_err;
        bit          done = 1'b0;

        lsu_mem_slave #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(LAT)) dut (
            .clk(clk), .rst_n(rst_n),
            .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
            .req_wen(req_wen), .req_wdata(req_wdata), .req_mask(req_mask),
            .resp_valid(resp_valid), .resp_ready(resp_ready),
            .resp_rdata(resp_rdata), .resp_err(resp_err)
        );

        // Transaction-level model: one pending request, executed LAT edges after acceptance.
        logic [63:0] mmem [DEPTH];
        bit          m_out = 1'b0;
        bit          m_pend = 1'b0;
        bit          m_rv = 1'b0;
        int          cyc = 0;
        int          m_due = 0;
        logic [63:0] m_addr, m_wdata, m_rdata;
        logic [7:0]  m_mask;
        logic        m_wen, m_err;

        task automatic model_access();
            int unsigned idx;
            logic [63:0] lm;
            lm = lanes(m_mask);
            m_rdata = '0;
            m_err = 1'b0;
            if (m_addr < BASE || m_addr >= LIMIT) begin
                m_err = 1'b1;
            end else begin
                idx = int'((m_addr - BASE) / 64'd8);
                if (m_wen) mmem[idx] = (mmem[idx] & ~lm) | (m_wdata & lm);
                else       m_rdata = mmem[idx] & lm;
            end
        endtask

        always @(negedge rst_n) begin
            m_out = 1'b0;
            m_pend = 1'b0;
            m_rv = 1'b0;
        end

        always @(posedge clk) begin
            cyc++;
            if (rst_n) begin
                if (m_rv && resp_ready) begin
                    m_rv = 1'b0;
                    m_pend = 1'b0;
                end else if (m_pend && !m_rv && cyc == m_due) begin
                    model_access();
                    m_rv = 1'b1;
                end else if (m_out && !m_pend && req_valid) begin
                    m_pend = 1'b1;
                    m_due = cyc + LAT;
                    m_addr = req_addr;
                    m_wen = req_wen;
                    m_wdata = req_wdata;
                    m_mask = req_mask;
                end
                m_out = 1'b1;
            end
        end

        always @(negedge clk) begin
            check(LAT, "req_ready", 64'(req_ready), 64'(m_out && !m_pend));
            check(LAT, "resp_valid", 64'(resp_valid), 64'(m_rv));
            if (m_rv) begin
                check(LAT, "resp_rdata", resp_rdata, m_rdata);
                check(LAT, "resp_err", 64'(resp_err), 64'(m_err));
            end
        end

        task automatic wait_ready(output bit ok);
            ok = 1'b0;
            for (int t = 0; t < 50; t++) begin
                if (req_ready) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!ok) timeout(LAT, "req_ready");
        endtask

        task automatic do_req(input logic [63:0] a, input logic w, input logic [63:0] d,
                              input logic [7:0] m, input int bp,
                              output logic [63:0] rd, output logic re);
            bit ok;
            rd = '0;
            re = 1'b0;
            @(negedge clk);
            req_valid = 1'b1;
            req_addr = a;
            req_wen = w;
            req_wdata = d;
            req_mask = m;
            resp_ready = (bp == 0);
            wait_ready(ok);
            if (!ok) begin
                req_valid = 1'b0;
                return;
            end
            @(negedge clk);
            req_valid = 1'b0;
            req_addr = {$urandom, $urandom};
            req_wen = 1'($urandom);
            req_wdata = {$urandom, $urandom};
            req_mask = 8'($urandom);
            ok = 1'b0;
            for (int t = 0; t < 40; t++) begin
                if (resp_valid) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!ok) begin
                timeout(LAT, "resp_valid");
                resp_ready = 1'b1;
                return;
            end
            rd = resp_rdata;
            re = resp_err;
            for (int t = 0; t < bp; t++) begin
                @(negedge clk);
                req_valid = ~req_valid;
            end
            req_valid = 1'b0;
            resp_ready = 1'b1;
        endtask

        initial begin
            logic [63:0] rd;
            logic        re;
            logic [63:0] a;
            bit          ok;
            rst_n = 1'b0;
            #1;
            check(LAT, "rst req_ready", 64'(req_ready), 64'd0);
            check(LAT, "rst resp_valid", 64'(resp_valid), 64'd0);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;

            do_req(64'h8000_0010, 1'b1, 64'h1122_3344_5566_7788, 8'hFF, 0, rd, re);
            check(LAT, "store rdata", rd, 64'd0);
            do_req(64'h8000_0010, 1'b0, 64'd0, 8'hFF, 0, rd, re);
            check(LAT, "full load", rd, 64'h1122_3344_5566_7788);
            check(LAT, "full load err", 64'(re), 64'd0);

            do_req(64'h8000_0010, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 0, rd, re);
            do_req(64'h8000_0010, 1'b0, 64'd0, 8'hFF, 0, rd, re);
            check(LAT, "partial store", rd, 64'h1122_3344_AAAA_AAAA);
            do_req(64'h8000_0013, 1'b0, 64'd0, 8'h03, 0, rd, re);
            check(LAT, "mask 03 load", rd, 64'h0000_0000_0000_AAAA);

            do_req(LIMIT - 64'd8, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 0, rd, re);
            do_req(LIMIT, 1'b0, 64'd0, 8'hFF, 0, rd, re);
            check(LAT, "oor high err", 64'(re), 64'd1);
            check(LAT, "oor high rdata", rd, 64'd0);
            do_req(64'h7FFF_FFF8, 1'b0, 64'd0, 8'hFF, 0, rd, re);
            check(LAT, "oor low err", 64'(re), 64'd1);
            do_req(LIMIT, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, rd, re);
            check(LAT, "oor store err", 64'(re), 64'd1);
            do_req(LIMIT - 64'd8, 1'b0, 64'd0, 8'hFF, 0, rd, re);
            check(LAT, "last word kept", rd, 64'hDEAD_BEEF_CAFE_F00D);

            do_req(64'h8000_0010, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, rd, re);
            check(LAT, "mask0 store err", 64'(re), 64'd0);
            do_req(64'h8000_0010, 1'b0, 64'd0, 8'h00, 0, rd, re);
            check(LAT, "mask0 load", rd, 64'd0);

            do_req(64'h8000_0010, 1'b0, 64'd0, 8'hFF, 5, rd, re);
            check(LAT, "backpressure load", rd, 64'h1122_3344_AAAA_AAAA);

            // Reset while a store waits for its access cycle: the store must never land.
            @(negedge clk);
            req_valid = 1'b1;
            req_addr = 64'h8000_0010;
            req_wen = 1'b1;
            req_wdata = 64'h5555_5555_5555_5555;
            req_mask = 8'hFF;
            wait_ready(ok);
            @(negedge clk);
            req_valid = 1'b0;
            #1 rst_n = 1'b0;
            #1;
            check(LAT, "async rst req_ready", 64'(req_ready), 64'd0);
            check(LAT, "async rst resp_valid", 64'(resp_valid), 64'd0);
            check(LAT, "async rst resp_rdata", resp_rdata, 64'd0);
            check(LAT, "async rst resp_err", 64'(resp_err), 64'd0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            #1 check(LAT, "ready before edge", 64'(req_ready), 64'd0);
            @(negedge clk);
            check(LAT, "ready after edge", 64'(req_ready), 64'd1);
            repeat (LAT + 2) @(negedge clk);
            do_req(64'h8000_0010, 1'b0, 64'd0, 8'hFF, 0, rd, re);
            check(LAT, "abandoned store", rd, 64'h1122_3344_AAAA_AAAA);

            for (int i = 0; i < 16; i++)
                do_req(BASE + 64'(i) * 64'd8, 1'b1, {$urandom, $urandom}, 8'hFF, 0, rd, re);
            for (int n = 0; n < 100; n++) begin
                if ($urandom_range(0, 7) == 0)
                    a = ($urandom_range(0, 1) == 1) ? LIMIT + 64'd8 * 64'($urandom_range(0, 3))
                                                    : BASE - 64'd8 * 64'($urandom_range(1, 4));
                else
                    a = BASE + 64'd8 * 64'($urandom_range(0, 15)) + 64'($urandom_range(0, 7));
                do_req(a, 1'($urandom), {$urandom, $urandom}, 8'($urandom), int'($urandom_range(0, 2)), rd, re);
            end
            repeat (3) @(negedge clk);
            done = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 60000; i++) begin
            @(posedge clk);
            if (g_inst[0].done && g_inst[1].done && g_inst[2].done) break;
        end
        if (!(g_inst[0].done && g_inst[1].done && g_inst[2].done)) timeout(0, "all instances done");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
